inverse_permuter: RTL and testbench

- Sequential inverse of the OSD column permuter.
- Takes a codeword in permuted (reliability-sorted) column order plus the permutation lambda1 that produced it. Scatters each bit back to its original column position, one column per cycle.
- Also emits the inverse permutation table and flags any lambda1 that is not a valid permutation.
- Sits after re-encoding in the OSD datapath, returning candidate codewords to channel order.

---
 rtl/osd_pkg.sv | 21 ++
 rtl/idx_onehot_dec.sv | 23 ++
 rtl/inverse_permuter.sv | 115 +++++++++++
 tb/tb_inverse_permuter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared definitions for the OSD datapath blocks: FSM states and
// column-index helpers.
package osd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCATTER,
    DONE
  } state_t;

  // Width of a column index for an n-column code (never narrower than 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when idx names an existing column of an n-column code.
  function automatic logic is_valid_idx(input int idx, input int n);
    return (idx >= 0) && (idx < n);
  endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Column index to one-hot decoder with a range flag. The one-hot vector is
// all zeros when the index does not name an existing column.
module idx_onehot_dec
  import osd_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             in_range
);

  // Decode the index and flag indices outside the column range.
  always_comb begin
    onehot   = '0;
    in_range = is_valid_idx(int'(idx), N);
    for (int j = 0; j < N; j++) begin
      onehot[j] = (int'(idx) == j);
    end
  end

endmodule

// File: rtl/inverse_permuter.sv
// Sequential inverse column permuter. Scatters a codeword given in permuted
// order back to original column order, one column per cycle, while building
// the inverse permutation table and flagging an invalid lambda1.
module inverse_permuter
  import osd_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       cw_perm,
  input  logic [N*IDX_W-1:0] lambda1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       cw_orig,
  output logic [N*IDX_W-1:0] lambda_inv,
  output logic               perm_err
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N - 1);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   cnt;
  logic [N-1:0]       cw_perm_reg;
  logic [N*IDX_W-1:0] lambda_reg;
  logic [N-1:0]       seen;

  logic [IDX_W-1:0]   cur_idx;
  logic               cur_bit;
  logic [N-1:0]       cur_onehot;
  logic               cur_in_range;
  logic               cur_bad;
  logic               accept;

  assign accept  = (state == IDLE) && in_valid && in_ready;
  assign cur_idx = lambda_reg[int'(cnt)*IDX_W +: IDX_W];
  assign cur_bit = cw_perm_reg[cnt];

  idx_onehot_dec #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx      (cur_idx),
    .onehot   (cur_onehot),
    .in_range (cur_in_range)
  );

  // An entry is rejected when it is out of range or its target was already
  // claimed by an earlier column (first occurrence wins).
  assign cur_bad = !cur_in_range || ((cur_onehot & seen) != '0);

  // Next-state logic: accept in IDLE, walk all columns, hold until drained.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SCATTER;
      SCATTER: if (cnt == LAST_CNT) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  // Capture on accept, then scatter one column per cycle; results hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      cw_perm_reg <= '0;
      lambda_reg  <= '0;
      seen        <= '0;
      cw_orig     <= '0;
      lambda_inv  <= '0;
      perm_err    <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      cw_perm_reg <= cw_perm;
      lambda_reg  <= lambda1;
      seen        <= '0;
      cw_orig     <= '0;
      lambda_inv  <= '0;
      perm_err    <= 1'b0;
    end else if (state == SCATTER) begin
      if (cur_bad) begin
        perm_err <= 1'b1;
      end else begin
        for (int j = 0; j < N; j++) begin
          if (cur_onehot[j]) begin
            cw_orig[j]                  <= cur_bit;
            lambda_inv[j*IDX_W +: IDX_W] <= cnt;
            seen[j]                     <= 1'b1;
          end
        end
      end
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_inverse_permuter.sv
// Directed bench for inverse_permuter (N=8, 3-bit indices).
module tb_inverse_permuter;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       cw_perm;
  logic [N*IDX_W-1:0] lambda1;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       cw_orig;
  logic [N*IDX_W-1:0] lambda_inv;
  logic               perm_err;

  int n_checks = 0;
  int n_fail   = 0;

  inverse_permuter #(.N(N), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cw_perm    (cw_perm),
    .lambda1    (lambda1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cw_orig    (cw_orig),
    .lambda_inv (lambda_inv),
    .perm_err   (perm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack eight 3-bit fields, field c at bits [3c+2:3c].
  function automatic logic [23:0] lam(input int f0, input int f1, input int f2, input int f3,
                                      input int f4, input int f5, input int f6, input int f7);
    return {3'(f7), 3'(f6), 3'(f5), 3'(f4), 3'(f3), 3'(f2), 3'(f1), 3'(f0)};
  endfunction

  // Wait (bounded) for in_ready, then present one transfer for one edge.
  task automatic send(input logic [7:0] cw, input logic [23:0] lm);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    cw_perm  = cw;
    lambda1  = lm;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cw_perm = '0; lambda1 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_checks++; if (cw_orig !== 8'h00) begin n_fail++; $display("FAIL rst_cw_orig: got %h required 00", cw_orig); end
    n_checks++; if (lambda_inv !== 24'h0) begin n_fail++; $display("FAIL rst_lambda_inv: got %h required 000000", lambda_inv); end
    n_checks++; if (perm_err !== 1'b0) begin n_fail++; $display("FAIL rst_perm_err: got %b required 0", perm_err); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_before_edge: in_ready=%b required 0", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_after_edge: in_ready=%b required 1", in_ready); end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b required 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_identity();
    int lat;
    send(8'hA5, lam(0, 1, 2, 3, 4, 5, 6, 7));
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL id_busy: in_ready=%b required 0", in_ready); end
    wait_out(lat);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL id_latency: got %0d cycles required 8", lat); end
    n_checks++; if (cw_orig !== 8'hA5) begin n_fail++; $display("FAIL id_cw_orig: got %h required a5", cw_orig); end
    n_checks++; if (lambda_inv !== lam(0, 1, 2, 3, 4, 5, 6, 7)) begin n_fail++; $display("FAIL id_lambda_inv: got %h required %h", lambda_inv, lam(0, 1, 2, 3, 4, 5, 6, 7)); end
    n_checks++; if (perm_err !== 1'b0) begin n_fail++; $display("FAIL id_perm_err: got %b required 0", perm_err); end
    drain();
  endtask

  // Reverse permutation with downstream stalled for 5 cycles, then a
  // back-to-back transfer with the mixed permutation.
  task automatic test_back_to_back();
    int lat;
    send(8'b0000_0011, lam(7, 6, 5, 4, 3, 2, 1, 0));
    wait_out(lat);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL rev_latency: got %0d cycles required 8", lat); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cw_orig !== 8'b1100_0000 ||
          lambda_inv !== lam(7, 6, 5, 4, 3, 2, 1, 0) || perm_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rev_hold[%0d]: v=%b rdy=%b cw=%h inv=%h err=%b required v=1 rdy=0 cw=c0 inv=%h err=0",
                 k, out_valid, in_ready, cw_orig, lambda_inv, perm_err, lam(7, 6, 5, 4, 3, 2, 1, 0));
      end
      @(posedge clk); #1;
    end
    drain();
    send(8'b1000_0001, lam(3, 0, 7, 1, 6, 2, 5, 4));
    wait_out(lat);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL mix_latency: got %0d cycles required 8", lat); end
    n_checks++; if (cw_orig !== 8'h18) begin n_fail++; $display("FAIL mix_cw_orig: got %h required 18", cw_orig); end
    n_checks++; if (lambda_inv !== lam(1, 3, 5, 0, 7, 6, 4, 2)) begin n_fail++; $display("FAIL mix_lambda_inv: got %h required %h", lambda_inv, lam(1, 3, 5, 0, 7, 6, 4, 2)); end
    n_checks++; if (perm_err !== 1'b0) begin n_fail++; $display("FAIL mix_perm_err: got %b required 0", perm_err); end
    drain();
  endtask

  task automatic test_duplicate();
    int lat;
    send(8'hFF, lam(0, 1, 2, 3, 4, 5, 6, 6));
    wait_out(lat);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL dup_latency: got %0d cycles required 8", lat); end
    n_checks++; if (perm_err !== 1'b1) begin n_fail++; $display("FAIL dup_perm_err: got %b required 1", perm_err); end
    n_checks++; if (cw_orig !== 8'h7F) begin n_fail++; $display("FAIL dup_cw_orig: got %h required 7f", cw_orig); end
    n_checks++; if (lambda_inv !== lam(0, 1, 2, 3, 4, 5, 6, 0)) begin n_fail++; $display("FAIL dup_lambda_inv: got %h required %h", lambda_inv, lam(0, 1, 2, 3, 4, 5, 6, 0)); end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(8'hFF, lam(0, 1, 2, 3, 4, 5, 6, 7));
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (cw_orig !== 8'h0F) begin n_fail++; $display("FAIL mid_partial: cw_orig=%h required 0f", cw_orig); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cw_orig !== 8'h00 || lambda_inv !== 24'h0 || perm_err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: cw=%h inv=%h err=%b v=%b rdy=%b required all 0",
               cw_orig, lambda_inv, perm_err, out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b required 1", in_ready); end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_valid[%0d]: out_valid=%b required 0", k, out_valid); end
      @(posedge clk); #1;
    end
    send(8'b0000_0011, lam(7, 6, 5, 4, 3, 2, 1, 0));
    wait_out(lat);
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL post_latency: got %0d cycles required 8", lat); end
    n_checks++; if (cw_orig !== 8'hC0) begin n_fail++; $display("FAIL post_cw_orig: got %h required c0", cw_orig); end
    n_checks++; if (lambda_inv !== lam(7, 6, 5, 4, 3, 2, 1, 0)) begin n_fail++; $display("FAIL post_lambda_inv: got %h required %h", lambda_inv, lam(7, 6, 5, 4, 3, 2, 1, 0)); end
    n_checks++; if (perm_err !== 1'b0) begin n_fail++; $display("FAIL post_perm_err: got %b required 0", perm_err); end
    drain();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_duplicate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
